// File: rtl/task_sched_pkg.sv
// Shared types for the task dispatcher: task word width, FSM state encoding and task type.
package task_sched_pkg;

  localparam int TASK_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  typedef logic [TASK_W-1:0] task_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr, wrapping around.
module rr_arbiter
  import task_sched_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_SRC-1:0] gnt,
  output logic [IDX_W-1:0]   idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_SRC);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/task_dispatcher.sv
// Round-robin feeder for task_scheduler with in-flight tracking.
// Define TASK_DISPATCH_CNT_EN to add per-source dispatch counters on output dispatch_cnt.
module task_dispatcher
  import task_sched_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int TASK_W  = task_sched_pkg::TASK_W,
  parameter int MAX_OUT = 8,
  parameter int OUT_W   = $clog2(MAX_OUT + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*TASK_W-1:0] src_task,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ack,
  output logic [TASK_W-1:0]         new_task,
  output logic                      task_valid,
  input  logic                      full,
  input  logic                      task_done,
  output logic [OUT_W-1:0]          outstanding,
  output logic                      busy,
  output logic                      err_underflow
`ifdef TASK_DISPATCH_CNT_EN
  , output logic [NUM_SRC*16-1:0]   dispatch_cnt
`endif
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W-1:0]   arb_idx;
  logic [NUM_SRC-1:0] arb_gnt;
  logic               dispatch;

  rr_arbiter #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req (src_valid),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  // full and the in-flight limit only gate a new dispatch from IDLE.
  assign dispatch = (state == IDLE) && (|src_valid) && !full &&
                    (outstanding < OUT_W'(MAX_OUT));

  assign busy = (state != IDLE) || (outstanding != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      grant_idx  <= '0;
      new_task   <= '0;
      task_valid <= 1'b0;
      src_ack    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dispatch) begin
            new_task   <= src_task[arb_idx*TASK_W +: TASK_W];
            task_valid <= 1'b1;
            src_ack    <= arb_gnt;
            grant_idx  <= arb_idx;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          task_valid <= 1'b0;
          src_ack    <= '0;
          rr_ptr     <= (grant_idx == IDX_W'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;
          state      <= GAP;
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          task_valid <= 1'b0;
          src_ack    <= '0;
          state      <= IDLE;
        end
      endcase
    end
  end

  // A dispatch and a completion on the same edge cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding   <= '0;
      err_underflow <= 1'b0;
    end else if (dispatch && !task_done) begin
      outstanding <= outstanding + 1'b1;
    end else if (!dispatch && task_done) begin
      if (outstanding == '0) begin
        err_underflow <= 1'b1;
      end else begin
        outstanding <= outstanding - 1'b1;
      end
    end
  end

`ifdef TASK_DISPATCH_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      dispatch_cnt <= '0;
    end else if (dispatch) begin
      dispatch_cnt[arb_idx*16 +: 16] <= dispatch_cnt[arb_idx*16 +: 16] + 16'd1;
    end
  end
`else
  // Per-source counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_task_dispatcher.sv
// Directed self-checking bench for task_dispatcher: one default instance and one with MAX_OUT=2.
module tb_task_dispatcher;
  import task_sched_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] src_task;
  logic [3:0]  src_valid;
  logic [3:0]  src_ack;
  task_t       new_task;
  logic        task_valid;
  logic        full;
  logic        task_done;
  logic [3:0]  outstanding;
  logic        busy;
  logic        err_underflow;

  logic [31:0] src_task_b;
  logic [3:0]  src_valid_b;
  logic [3:0]  src_ack_b;
  task_t       new_task_b;
  logic        task_valid_b;
  logic        task_done_b;
  logic [1:0]  outstanding_b;
  logic        busy_b;
  logic        err_underflow_b;

`ifdef TASK_DISPATCH_CNT_EN
  logic [63:0] cnt_a;
  logic [63:0] cnt_b;
`endif

  int total = 0;
  int bad   = 0;

  int          exp_src [5] = '{0, 1, 2, 3, 0};
  logic [7:0]  exp_task[5] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3, 8'hE0};
  logic [31:0] cur;

  task_dispatcher #(.NUM_SRC(4), .TASK_W(8), .MAX_OUT(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .src_task      (src_task),
    .src_valid     (src_valid),
    .src_ack       (src_ack),
    .new_task      (new_task),
    .task_valid    (task_valid),
    .full          (full),
    .task_done     (task_done),
    .outstanding   (outstanding),
    .busy          (busy),
    .err_underflow (err_underflow)
`ifdef TASK_DISPATCH_CNT_EN
    , .dispatch_cnt (cnt_a)
`endif
  );

  task_dispatcher #(.NUM_SRC(4), .TASK_W(8), .MAX_OUT(2)) dut_b (
    .clk           (clk),
    .rst           (rst),
    .src_task      (src_task_b),
    .src_valid     (src_valid_b),
    .src_ack       (src_ack_b),
    .new_task      (new_task_b),
    .task_valid    (task_valid_b),
    .full          (1'b0),
    .task_done     (task_done_b),
    .outstanding   (outstanding_b),
    .busy          (busy_b),
    .err_underflow (err_underflow_b)
`ifdef TASK_DISPATCH_CNT_EN
    , .dispatch_cnt (cnt_b)
`endif
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic [31:0] tasks,
                               input logic f, input logic done);
    src_valid = valid;
    src_task  = tasks;
    full      = f;
    task_done = done;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    applyStimulus(4'b0000, 32'h0, 1'b0, 1'b0);
    src_valid_b = '0;
    src_task_b  = '0;
    task_done_b = 1'b0;
    doReset();
    checkOutput("rst_valid", task_valid, 0);
    checkOutput("rst_ack", src_ack, 0);
    checkOutput("rst_task", new_task, 0);
    checkOutput("rst_out", outstanding, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_err", err_underflow, 0);
    checkOutput("rst_out_b", outstanding_b, 0);

    $display("[TB] single source, tasks 01..05");
    applyStimulus(4'b0001, 32'h01, 1'b0, 1'b0);
    for (int t = 1; t <= 5; t++) begin
      tick();
      checkOutput("t1_valid", task_valid, 1);
      checkOutput("t1_task", new_task, t);
      checkOutput("t1_ack", src_ack, 4'b0001);
      if (t < 5) applyStimulus(4'b0001, 32'(t + 1), 1'b0, 1'b0);
      else       applyStimulus(4'b0000, 32'h0, 1'b0, 1'b0);
      tick();
      checkOutput("t1_gap1", task_valid, 0);
      tick();
      checkOutput("t1_gap2", task_valid, 0);
    end
    checkOutput("t1_out", outstanding, 5);
    checkOutput("t1_busy", busy, 1);
    checkOutput("t1_hold", new_task, 8'h05);

    $display("[TB] four sources round-robin");
    doReset();
    cur = 32'hD3C2B1A0;
    applyStimulus(4'b1111, cur, 1'b0, 1'b0);
    for (int g = 0; g < 5; g++) begin
      tick();
      checkOutput("t2_valid", task_valid, 1);
      checkOutput("t2_ack", src_ack, 32'(1) << exp_src[g]);
      checkOutput("t2_task", new_task, exp_task[g]);
      if (g < 4) begin
        cur[exp_src[g]*8 +: 8] = 8'hE0 + 8'(exp_src[g]);
        applyStimulus(4'b1111, cur, 1'b0, 1'b0);
      end else begin
        applyStimulus(4'b0000, 32'h0, 1'b0, 1'b0);
      end
      tick();
      tick();
    end
    checkOutput("t2_out", outstanding, 5);

    $display("[TB] full blocks dispatch");
    doReset();
    applyStimulus(4'b0001, 32'h55, 1'b1, 1'b0);
    for (int c = 0; c < 10; c++) begin
      tick();
      checkOutput("t3_full_valid", task_valid, 0);
      checkOutput("t3_full_ack", src_ack, 0);
    end
    applyStimulus(4'b0001, 32'h55, 1'b0, 1'b0);
    tick();
    checkOutput("t3_rel_valid", task_valid, 1);
    checkOutput("t3_rel_task", new_task, 8'h55);
    applyStimulus(4'b0000, 32'h0, 1'b0, 1'b0);
    tick();
    tick();

    $display("[TB] in-flight limit with MAX_OUT=2");
    src_task_b  = 32'h00332211;
    src_valid_b = 4'b0111;
    tick();
    checkOutput("t4_v1", task_valid_b, 1);
    checkOutput("t4_task1", new_task_b, 8'h11);
    checkOutput("t4_ack1", src_ack_b, 4'b0001);
    src_valid_b = 4'b0110;
    tick();
    tick();
    tick();
    checkOutput("t4_v2", task_valid_b, 1);
    checkOutput("t4_task2", new_task_b, 8'h22);
    checkOutput("t4_ack2", src_ack_b, 4'b0010);
    src_valid_b = 4'b0100;
    for (int c = 0; c < 6; c++) begin
      tick();
      checkOutput("t4_blocked", task_valid_b, 0);
    end
    checkOutput("t4_out_max", outstanding_b, 2);
    task_done_b = 1'b1;
    tick();
    task_done_b = 1'b0;
    checkOutput("t4_out_dec", outstanding_b, 1);
    tick();
    checkOutput("t4_v3", task_valid_b, 1);
    checkOutput("t4_task3", new_task_b, 8'h33);
    checkOutput("t4_out_back", outstanding_b, 2);
    src_valid_b = 4'b0000;
    tick();
    tick();

    $display("[TB] underflow and simultaneous done");
    doReset();
    applyStimulus(4'b0000, 32'h0, 1'b0, 1'b1);
    tick();
    applyStimulus(4'b0000, 32'h0, 1'b0, 1'b0);
    checkOutput("t5_err", err_underflow, 1);
    checkOutput("t5_out0", outstanding, 0);
    tick();
    tick();
    checkOutput("t5_err_sticky", err_underflow, 1);
    checkOutput("t5_busy", busy, 0);
    applyStimulus(4'b0001, 32'h77, 1'b0, 1'b0);
    tick();
    checkOutput("t5_v1", task_valid, 1);
    checkOutput("t5_out1", outstanding, 1);
    applyStimulus(4'b0000, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    applyStimulus(4'b0001, 32'h78, 1'b0, 1'b1);
    tick();
    checkOutput("t5_v2", task_valid, 1);
    checkOutput("t5_task2", new_task, 8'h78);
    checkOutput("t5_out_same", outstanding, 1);
    applyStimulus(4'b0000, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("t5_err_end", err_underflow, 1);

    $display("[TB] reset during ISSUE");
    doReset();
    checkOutput("t6_err_clr", err_underflow, 0);
    applyStimulus(4'b0001, 32'h99, 1'b0, 1'b0);
    tick();
    checkOutput("t6_issue", task_valid, 1);
    rst = 1'b1;
    tick();
    checkOutput("t6_valid", task_valid, 0);
    checkOutput("t6_ack", src_ack, 0);
    checkOutput("t6_out", outstanding, 0);
    checkOutput("t6_busy", busy, 0);
    rst = 1'b0;
    tick();
    checkOutput("t6_redo_valid", task_valid, 1);
    checkOutput("t6_redo_ack", src_ack, 4'b0001);
    checkOutput("t6_redo_task", new_task, 8'h99);
    checkOutput("t6_redo_out", outstanding, 1);
    applyStimulus(4'b0000, 32'h0, 1'b0, 1'b0);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
